vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, delayed sync pipeline and blanked colour drive
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  // Pixel periods between the counters and pixel_rgb returning; legal 1..4
  parameter int PIPE_DELAY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pixel_rgb,
  output logic       px_en,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       video_on,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [1:0] vga_b
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);

  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic                  px_en_q, px_en_d;
  logic [9:0]            h_count_q, h_count_d;
  logic [9:0]            v_count_q, v_count_d;
  logic [PIPE_DELAY-1:0] hsync_pipe_q, hsync_pipe_d;
  logic [PIPE_DELAY-1:0] vsync_pipe_q, vsync_pipe_d;
  logic [PIPE_DELAY-1:0] video_pipe_q, video_pipe_d;
  logic [2:0]            vga_r_q, vga_r_d;
  logic [2:0]            vga_g_q, vga_g_d;
  logic [1:0]            vga_b_q, vga_b_d;

  logic hsync_raw;
  logic vsync_raw;
  logic video_raw;
  logic h_wrap;
  logic v_wrap;

  assign h_wrap = (h_count_q == H_LAST);
  assign v_wrap = (v_count_q == V_LAST);

  // Undelayed raster decode straight from the counters
  always_comb begin
    video_raw = (h_count_q < H_VIS) && (v_count_q < V_VIS);
    hsync_raw = !((h_count_q >= H_SYNC_FIRST) && (h_count_q <= H_SYNC_LAST));
    vsync_raw = !((v_count_q >= V_SYNC_FIRST) && (v_count_q <= V_SYNC_LAST));
  end

  // Pixel enable toggles every clk; counters step once per pixel, row carries on line wrap
  always_comb begin
    px_en_d   = ~px_en_q;
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (px_en_q) begin
      if (h_wrap) begin
        h_count_d = '0;
        v_count_d = v_wrap ? 10'd0 : v_count_q + 10'd1;
      end else begin
        h_count_d = h_count_q + 10'd1;
      end
    end
  end

  // Sync and video-enable delay line, shifted only on pixel edges so it tracks pixel_rgb latency
  always_comb begin
    hsync_pipe_d = hsync_pipe_q;
    vsync_pipe_d = vsync_pipe_q;
    video_pipe_d = video_pipe_q;
    if (px_en_q) begin
      hsync_pipe_d[0] = hsync_raw;
      vsync_pipe_d[0] = vsync_raw;
      video_pipe_d[0] = video_raw;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        hsync_pipe_d[i] = hsync_pipe_q[i-1];
        vsync_pipe_d[i] = vsync_pipe_q[i-1];
        video_pipe_d[i] = video_pipe_q[i-1];
      end
    end
  end

  // Colour register: capture the returning pixel when its delayed enable is set, else blank
  always_comb begin
    vga_r_d = vga_r_q;
    vga_g_d = vga_g_q;
    vga_b_d = vga_b_q;
    if (px_en_q) begin
      if (video_pipe_q[PIPE_DELAY-1]) begin
        vga_r_d = pixel_rgb[7:5];
        vga_g_d = pixel_rgb[4:2];
        vga_b_d = pixel_rgb[1:0];
      end else begin
        vga_r_d = '0;
        vga_g_d = '0;
        vga_b_d = '0;
      end
    end
  end

  // State registers; reset parks the raster at (0,0) with syncs idle and colour dark
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px_en_q      <= 1'b0;
      h_count_q    <= '0;
      v_count_q    <= '0;
      hsync_pipe_q <= '1;
      vsync_pipe_q <= '1;
      video_pipe_q <= '0;
      vga_r_q      <= '0;
      vga_g_q      <= '0;
      vga_b_q      <= '0;
    end else begin
      px_en_q      <= px_en_d;
      h_count_q    <= h_count_d;
      v_count_q    <= v_count_d;
      hsync_pipe_q <= hsync_pipe_d;
      vsync_pipe_q <= vsync_pipe_d;
      video_pipe_q <= video_pipe_d;
      vga_r_q      <= vga_r_d;
      vga_g_q      <= vga_g_d;
      vga_b_q      <= vga_b_d;
    end
  end

  // frame_start is decoded rather than stored so it is exactly the px_en-high clk at (0,0)
  assign frame_start = px_en_q && (h_count_q == 10'd0) && (v_count_q == 10'd0);

  assign px_en    = px_en_q;
  assign h_count  = h_count_q;
  assign v_count  = v_count_q;
  assign video_on = video_raw;
  assign hsync    = hsync_pipe_q[PIPE_DELAY-1];
  assign vsync    = vsync_pipe_q[PIPE_DELAY-1];
  assign vga_r    = vga_r_q;
  assign vga_g    = vga_g_q;
  assign vga_b    = vga_b_q;

endmodule
